cpu_controller: RTL
===================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge system clock.
REQ-002 SHALL have port: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: s  in  1  start; begins execution of held instruction.
REQ-004 SHALL have port: load  in  1  instruction register (IR) load enable.
REQ-005 SHALL have port: in  in  16  instruction word.
REQ-006 SHALL have port: w  out  1  idle flag; 1 only in WAIT.
REQ-007 SHALL have ports: readnum, writenum  out  3 each  register-file read/write addresses.
REQ-008 SHALL have ports: write, loada, loadb, asel, bsel, loadc, loads  out  1 each  datapath strobes/selects.
REQ-009 SHALL have ports: vsel  out  4  one-hot writeback select (0001 mdata, 0010 sximm8, 0100 PC, 1000 C); shift, ALUop  out  2 each.
REQ-010 SHALL have ports: sximm8, sximm5  out  16 each  sign-extended IR[7:0] and IR[4:0].

Function
REQ-011 IR fields SHALL be: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
REQ-012 IR SHALL capture in on rising clk when load=1 and w=1; load while w=0 SHALL be ignored.
REQ-013 sximm8/sximm5 SHALL be combinational from current IR, bit 7 / bit 4 replicated into upper bits.
REQ-014 Supported: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{sh}; 101/00 ADD Rd,Rn,Rm{sh}; 101/01 CMP Rn,Rm{sh}; 101/10 AND Rd,Rn,Rm{sh}; 101/11 MVN Rd,Rm{sh}.
REQ-015 Moore FSM states SHALL be WAIT, DECODE, WRITE_IMM, GET_A, GET_B, EXEC, WRITE_REG; outputs decoded combinationally from state and IR.
REQ-016 Default in every state: all strobes 0, asel=bsel=0, vsel=1000, shift=00, ALUop=00, readnum=writenum=000.
REQ-017 WAIT: w=1; s=1 at edge -> DECODE, else hold; s while w=0 SHALL be ignored.
REQ-018 DECODE: MOV imm -> WRITE_IMM; MOV reg or MVN -> GET_B; ADD/CMP/AND -> GET_A; any other opcode/op -> WAIT, no strobe asserted.
REQ-019 WRITE_IMM: writenum=Rn, vsel=0010, write=1 -> WAIT.
REQ-020 GET_A: readnum=Rn, loada=1 -> GET_B.
REQ-021 GET_B: readnum=Rm, loadb=1 -> EXEC.
REQ-022 EXEC: shift=sh, bsel=0; ALUop=op for 101 instructions, ALUop=00 with asel=1 for MOV reg; MVN asel=1.
REQ-023 EXEC: CMP asserts loads=1, loadc=0 -> WAIT; all others loadc=1, loads=0 -> WRITE_REG.
REQ-024 WRITE_REG: writenum=Rd, vsel=1000, write=1 -> WAIT.
REQ-025 Latency (s sampled to w=1): MOV imm 3 cycles; MOV reg/MVN 5; CMP 5; ADD/AND 6; illegal 2.
REQ-026 write SHALL never be asserted in consecutive cycles; loada, loadb, loadc, loads each at most once per instruction.

Reset
REQ-027 reset_n=0 SHALL force, immediately and asynchronously, state=WAIT, IR=0x0000, w=1, all strobes 0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no further write; first edge after release SHALL evaluate WAIT normally.

Verification
REQ-029 Load 0xD0FD, pulse s -> one-cycle write with writenum=0, vsel=0010, sximm8=0xFFFD; w=1 three cycles after s.
REQ-030 Load 0xA148 (ADD R2,R1,R0,LSL#1) -> GET_A readnum=1 loada; GET_B readnum=0 loadb; EXEC shift=01 ALUop=00 loadc; WRITE_REG writenum=2 write.
REQ-031 Load 0xA901 (CMP R1,R1) -> EXEC loads=1, loadc=0; no write; w=1 five cycles after s.
REQ-032 During ADD, drive load=1 with in=0xFFFF and s=1 -> IR unchanged, sequence unaffected.
REQ-033 Load 0xE000 (illegal), pulse s -> DECODE then WAIT, no strobes.
REQ-034 Assert reset_n=0 while in GET_B -> w=1 and loadb=0 same cycle; IR reads 0x0000; no write after release.

Source files
------------

// File: rtl/cpu_controller_if.sv
// Instruction/handshake bus between the sequencer and its surroundings:
// instruction input and start strobe in, datapath controls out.
interface cpu_controller_if;
   logic        s;
   logic        load;
   logic [15:0] in;
   logic        w;
   logic [2:0]  readnum;
   logic [2:0]  writenum;
   logic        write;
   logic        loada;
   logic        loadb;
   logic        asel;
   logic        bsel;
   logic        loadc;
   logic        loads;
   logic [3:0]  vsel;
   logic [1:0]  shift;
   logic [1:0]  ALUop;
   logic [15:0] sximm8;
   logic [15:0] sximm5;

   modport master (
      output s, load, in,
      input  w, readnum, writenum, write, loada, loadb, asel, bsel,
             loadc, loads, vsel, shift, ALUop, sximm8, sximm5
   );

   modport slave (
      input  s, load, in,
      output w, readnum, writenum, write, loada, loadb, asel, bsel,
             loadc, loads, vsel, shift, ALUop, sximm8, sximm5
   );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle Moore sequencer: holds one instruction word and steps the
// register-file/ALU datapath through MOV/ADD/CMP/AND/MVN.
module cpu_controller (
   input  logic             clk,
   input  logic             reset_n,
   cpu_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_WAIT      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_WRITE_IMM = 3'd2,
      ST_GET_A     = 3'd3,
      ST_GET_B     = 3'd4,
      ST_EXEC      = 3'd5,
      ST_WRITE_REG = 3'd6
   } state_t;

   state_t      state_r;
   logic [15:0] ir_r;

   logic [2:0]  opcode_s;
   logic [1:0]  op_s;
   logic [2:0]  rn_s;
   logic [2:0]  rd_s;
   logic [1:0]  sh_s;
   logic [2:0]  rm_s;
   logic        is_cmp_s;

   logic        w_s;
   logic        write_s;
   logic        loada_s;
   logic        loadb_s;
   logic        loadc_s;
   logic        loads_s;
   logic        asel_s;
   logic        bsel_s;
   logic [2:0]  readnum_s;
   logic [2:0]  writenum_s;
   logic [3:0]  vsel_s;
   logic [1:0]  shift_s;
   logic [1:0]  aluop_s;

   assign opcode_s = ir_r[15:13];
   assign op_s     = ir_r[12:11];
   assign rn_s     = ir_r[10:8];
   assign rd_s     = ir_r[7:5];
   assign sh_s     = ir_r[4:3];
   assign rm_s     = ir_r[2:0];
   assign is_cmp_s = (opcode_s == 3'b101) && (op_s == 2'b01);

   // Instruction register; a load is only honoured while the sequencer is idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir_r <= 16'h0000;
      end else if (bus.load && (state_r == ST_WAIT)) begin
         ir_r <= bus.in;
      end else begin
         ir_r <= ir_r;
      end
   end

   // Sequencer state transitions
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_WAIT;
      end else begin
         case (state_r)
            ST_WAIT: begin
               if (bus.s) state_r <= ST_DECODE;
               else       state_r <= ST_WAIT;
            end
            ST_DECODE: begin
               case ({opcode_s, op_s})
                  5'b110_10:                       state_r <= ST_WRITE_IMM;
                  5'b110_00, 5'b101_11:            state_r <= ST_GET_B;
                  5'b101_00, 5'b101_01, 5'b101_10: state_r <= ST_GET_A;
                  default:                         state_r <= ST_WAIT;
               endcase
            end
            ST_WRITE_IMM: state_r <= ST_WAIT;
            ST_GET_A:     state_r <= ST_GET_B;
            ST_GET_B:     state_r <= ST_EXEC;
            ST_EXEC: begin
               if (is_cmp_s) state_r <= ST_WAIT;
               else          state_r <= ST_WRITE_REG;
            end
            ST_WRITE_REG: state_r <= ST_WAIT;
            default:      state_r <= ST_WAIT;
         endcase
      end
   end

   // Moore output decode; decoding straight from state lets reset idle the outputs at once
   always_comb begin
      w_s        = 1'b0;
      write_s    = 1'b0;
      loada_s    = 1'b0;
      loadb_s    = 1'b0;
      loadc_s    = 1'b0;
      loads_s    = 1'b0;
      asel_s     = 1'b0;
      bsel_s     = 1'b0;
      readnum_s  = 3'd0;
      writenum_s = 3'd0;
      vsel_s     = 4'b1000;
      shift_s    = 2'b00;
      aluop_s    = 2'b00;
      case (state_r)
         ST_WAIT: w_s = 1'b1;
         ST_DECODE: begin
         end
         ST_WRITE_IMM: begin
            writenum_s = rn_s;
            vsel_s     = 4'b0010;
            write_s    = 1'b1;
         end
         ST_GET_A: begin
            readnum_s = rn_s;
            loada_s   = 1'b1;
         end
         ST_GET_B: begin
            readnum_s = rm_s;
            loadb_s   = 1'b1;
         end
         ST_EXEC: begin
            shift_s = sh_s;
            // Single-operand ops zero the A side so the ALU passes/inverts B
            if (opcode_s == 3'b101) begin
               aluop_s = op_s;
               asel_s  = (op_s == 2'b11);
            end else begin
               aluop_s = 2'b00;
               asel_s  = 1'b1;
            end
            if (is_cmp_s) loads_s = 1'b1;
            else          loadc_s = 1'b1;
         end
         ST_WRITE_REG: begin
            writenum_s = rd_s;
            vsel_s     = 4'b1000;
            write_s    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign bus.w        = w_s;
   assign bus.write    = write_s;
   assign bus.loada    = loada_s;
   assign bus.loadb    = loadb_s;
   assign bus.loadc    = loadc_s;
   assign bus.loads    = loads_s;
   assign bus.asel     = asel_s;
   assign bus.bsel     = bsel_s;
   assign bus.readnum  = readnum_s;
   assign bus.writenum = writenum_s;
   assign bus.vsel     = vsel_s;
   assign bus.shift    = shift_s;
   assign bus.ALUop    = aluop_s;
   assign bus.sximm8   = {{8{ir_r[7]}}, ir_r[7:0]};
   assign bus.sximm5   = {{11{ir_r[4]}}, ir_r[4:0]};

endmodule
